// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch stage that sits in front of the decoder.
// It owns the PC and issues one word fetch at a time over a
// request/grant/response interface. It holds one fetched instruction,
// with its PC, in an output buffer that uses a valid/ready handshake.
// Redirects from execute flush the buffer and discard any stale response.
// Optional feature macro: INST_FETCH_MISALIGN_FAULT_EN. It adds the
// fetch_fault port and reports misaligned redirect targets instead of
// masking their low bits.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
`ifdef INST_FETCH_MISALIGN_FAULT_EN
    ,
    output logic        fetch_fault
`endif
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic        r_inst_valid;
    logic        w_grant;
    logic        w_refill;
    logic        w_fault_hold;
    logic [31:0] w_target;

`ifdef INST_FETCH_MISALIGN_FAULT_EN
    logic        r_fault;
    logic        w_misaligned;

    // A misaligned target is loaded as-is and raises the fault.
    assign w_misaligned = |redirect_pc[1:0];
    assign w_target     = redirect_pc;
    assign w_fault_hold = r_fault;
    assign fetch_fault  = r_fault;
`else
    // The target is always word aligned: its two low bits are dropped.
    assign w_target     = redirect_pc & 32'hFFFF_FFFC;
    assign w_fault_hold = 1'b0;
`endif

    // A request is accepted this cycle.
    assign w_grant  = imem_req && imem_gnt;
    // A response is written into the buffer. A redirect in the same cycle
    // makes the response stale, so it is dropped.
    assign w_refill = (r_state == S_WAIT) && imem_rvalid && !redirect;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic. A redirect turns any request still in flight into a
    // stale one, and the DRAIN state then throws that response away.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_REQ: begin
                if (w_grant) begin
                    w_state_next = redirect ? S_DRAIN : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    w_state_next = S_REQ;
                end else if (redirect) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (imem_rvalid) begin
                    w_state_next = S_REQ;
                end
            end
            default: w_state_next = S_REQ;
        endcase
    end

    // Output logic. A request is issued only if the buffer will have room
    // this cycle: it is empty now, or the decoder is taking its contents.
    always_comb begin
        imem_req   = !reset && (r_state == S_REQ) &&
                     (!r_inst_valid || inst_ready) && !w_fault_hold;
        imem_addr  = r_pc;
        inst_valid = r_inst_valid;
        inst       = r_inst;
        inst_pc    = r_inst_pc;
    end

    // PC register and output buffer. A redirect takes priority over a
    // refill and over a consume.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc         <= RESET_PC;
            r_inst       <= 32'h0;
            r_inst_pc    <= 32'h0;
            r_inst_valid <= 1'b0;
        end else if (redirect) begin
            r_pc         <= w_target;
            r_inst_valid <= 1'b0;
        end else if (w_refill) begin
            r_inst       <= imem_rdata;
            r_inst_pc    <= r_pc;
            r_inst_valid <= 1'b1;
            r_pc         <= r_pc + PC_STEP;
        end else if (r_inst_valid && inst_ready) begin
            r_inst_valid <= 1'b0;
        end
    end

`ifdef INST_FETCH_MISALIGN_FAULT_EN
    // Fault flag. It is set by a misaligned redirect and cleared by the
    // next aligned redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fault <= 1'b0;
        end else if (redirect) begin
            r_fault <= w_misaligned;
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed testbench for inst_fetch. The bench drives every memory
// response and redirect itself, one clock cycle at a time, and compares
// the outputs with hand-computed values.
module tb_inst_fetch;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
`ifdef INST_FETCH_MISALIGN_FAULT_EN
    logic        fetch_fault;
`endif

    int n_tests;
    int n_fail;

    inst_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc)
`ifdef INST_FETCH_MISALIGN_FAULT_EN
        ,
        .fetch_fault (fetch_fault)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Go to 1 time unit after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Apply one cycle of inputs and let the combinational outputs settle.
    task automatic drive(input logic gnt, input logic rv, input logic [31:0] rdata,
                         input logic rd, input logic [31:0] rpc, input logic rdy);
        imem_gnt    = gnt;
        imem_rvalid = rv;
        imem_rdata  = rdata;
        redirect    = rd;
        redirect_pc = rpc;
        inst_ready  = rdy;
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        tick;
        check_eq("rst_req", {31'b0, imem_req}, 32'h0);
        check_eq("rst_valid", {31'b0, inst_valid}, 32'h0);
        check_eq("rst_inst", inst, 32'h0);
        check_eq("rst_inst_pc", inst_pc, 32'h0);
        check_eq("rst_addr", imem_addr, 32'h0);
`ifdef INST_FETCH_MISALIGN_FAULT_EN
        check_eq("rst_fault", {31'b0, fetch_fault}, 32'h0);
`endif
        tick;
        reset = 1'b0;
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

        // Sequential fetch with a 1-cycle memory and inst_ready held high.
        do_reset;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check_eq("t1_req0", {31'b0, imem_req}, 32'h1);
        check_eq("t1_addr0", imem_addr, 32'h0);
        tick;
        drive(1'b0, 1'b1, 32'h0050_0093, 1'b0, 32'h0, 1'b1);
        check_eq("t1_wait_req", {31'b0, imem_req}, 32'h0);
        check_eq("t1_wait_valid", {31'b0, inst_valid}, 32'h0);
        tick;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check_eq("t1_valid0", {31'b0, inst_valid}, 32'h1);
        check_eq("t1_inst0", inst, 32'h0050_0093);
        check_eq("t1_pc0", inst_pc, 32'h0);
        check_eq("t1_addr4", imem_addr, 32'h4);
        check_eq("t1_req4", {31'b0, imem_req}, 32'h1);
        tick;
        drive(1'b0, 1'b1, 32'h0010_0113, 1'b0, 32'h0, 1'b1);
        check_eq("t1_valid_gap", {31'b0, inst_valid}, 32'h0);
        tick;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check_eq("t1_inst4", inst, 32'h0010_0113);
        check_eq("t1_pc4", inst_pc, 32'h4);
        check_eq("t1_addr8", imem_addr, 32'h8);
        tick;

        // Redirect to 0x100 while waiting for the 0x8 response.
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b1);
        tick;
        drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1);
        check_eq("t3_drain_req", {31'b0, imem_req}, 32'h0);
        tick;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check_eq("t3_valid", {31'b0, inst_valid}, 32'h0);
        check_eq("t3_addr", imem_addr, 32'h100);
        check_eq("t3_req", {31'b0, imem_req}, 32'h1);
        tick;
        drive(1'b0, 1'b1, 32'h1111_1111, 1'b0, 32'h0, 1'b1);
        tick;
        check_eq("t3_inst", inst, 32'h1111_1111);
        check_eq("t3_pc", inst_pc, 32'h100);

        // Redirect arriving in the same cycle as imem_rvalid.
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check_eq("t4_addr104", imem_addr, 32'h104);
        tick;
        drive(1'b0, 1'b1, 32'h5555_5555, 1'b1, 32'h180, 1'b1);
        tick;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check_eq("t4_valid", {31'b0, inst_valid}, 32'h0);
        check_eq("t4_req", {31'b0, imem_req}, 32'h1);
        check_eq("t4_addr", imem_addr, 32'h180);
        tick;
        drive(1'b0, 1'b1, 32'h6666_6666, 1'b0, 32'h0, 1'b1);
        tick;
        check_eq("t4_inst", inst, 32'h6666_6666);
        check_eq("t4_pc", inst_pc, 32'h180);

        // Redirect to 0x200 while the buffered instruction is being consumed.
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1);
        tick;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check_eq("t5_valid", {31'b0, inst_valid}, 32'h0);
        check_eq("t5_addr", imem_addr, 32'h200);
        tick;
        drive(1'b0, 1'b1, 32'h2222_2222, 1'b0, 32'h0, 1'b1);
        tick;
        check_eq("t5_inst", inst, 32'h2222_2222);
        check_eq("t5_pc", inst_pc, 32'h200);

        // Redirect in REQ in the same cycle as a grant: the response is stale.
        drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h300, 1'b1);
        tick;
        drive(1'b0, 1'b1, 32'hBAD0_BAD0, 1'b0, 32'h0, 1'b1);
        check_eq("t6_drain_req", {31'b0, imem_req}, 32'h0);
        check_eq("t6_valid", {31'b0, inst_valid}, 32'h0);
        tick;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check_eq("t6_req", {31'b0, imem_req}, 32'h1);
        check_eq("t6_addr", imem_addr, 32'h300);
        tick;
        drive(1'b0, 1'b1, 32'h3030_3030, 1'b0, 32'h0, 1'b1);
        tick;
        check_eq("t6_inst", inst, 32'h3030_3030);
        check_eq("t6_pc", inst_pc, 32'h300);

        // The PC wraps from 0xFFFF_FFFC to 0.
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        tick;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check_eq("t7_addr_top", imem_addr, 32'hFFFF_FFFC);
        tick;
        drive(1'b0, 1'b1, 32'h7777_7777, 1'b0, 32'h0, 1'b1);
        tick;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check_eq("t7_pc_top", inst_pc, 32'hFFFF_FFFC);
        check_eq("t7_addr_wrap", imem_addr, 32'h0);

        // Misaligned redirect target.
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h102, 1'b1);
        tick;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
`ifdef INST_FETCH_MISALIGN_FAULT_EN
        check_eq("t8_fault", {31'b0, fetch_fault}, 32'h1);
        check_eq("t8_req_held", {31'b0, imem_req}, 32'h0);
        check_eq("t8_addr_raw", imem_addr, 32'h102);
        tick;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check_eq("t8_req_held2", {31'b0, imem_req}, 32'h0);
        tick;
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h104, 1'b1);
        tick;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check_eq("t8_fault_clr", {31'b0, fetch_fault}, 32'h0);
        check_eq("t8_req", {31'b0, imem_req}, 32'h1);
        check_eq("t8_addr", imem_addr, 32'h104);
        tick;
        drive(1'b0, 1'b1, 32'h3333_3333, 1'b0, 32'h0, 1'b1);
        tick;
        check_eq("t8_inst", inst, 32'h3333_3333);
        check_eq("t8_pc", inst_pc, 32'h104);
`else
        check_eq("t8_addr_masked", imem_addr, 32'h100);
        check_eq("t8_req", {31'b0, imem_req}, 32'h1);
`endif

        // Instruction not consumed: the request is held back and the buffer
        // stays stable.
        do_reset;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        tick;
        drive(1'b0, 1'b1, 32'h0050_0093, 1'b0, 32'h0, 1'b0);
        tick;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check_eq("t2_req_stall", {31'b0, imem_req}, 32'h0);
        check_eq("t2_inst", inst, 32'h0050_0093);
        tick;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check_eq("t2_req_stall2", {31'b0, imem_req}, 32'h0);
        check_eq("t2_inst_hold", inst, 32'h0050_0093);
        check_eq("t2_pc_hold", inst_pc, 32'h0);
        check_eq("t2_valid_hold", {31'b0, inst_valid}, 32'h1);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check_eq("t2_req_release", {31'b0, imem_req}, 32'h1);
        check_eq("t2_addr4", imem_addr, 32'h4);
        tick;
        drive(1'b0, 1'b1, 32'h0010_0113, 1'b0, 32'h0, 1'b1);
        check_eq("t2_consumed", {31'b0, inst_valid}, 32'h0);
        tick;
        check_eq("t2_pc4", inst_pc, 32'h4);

        // Reset abandons an outstanding request: a late response is ignored.
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        tick;
        do_reset;
        drive(1'b0, 1'b1, 32'hABCD_0123, 1'b0, 32'h0, 1'b1);
        tick;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check_eq("t9_late_rvalid", {31'b0, inst_valid}, 32'h0);
        check_eq("t9_addr", imem_addr, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction fetch stage directly upstream of the instruction decoder. It owns the PC, issues word fetches to instruction memory over a request/grant/response interface, and holds one fetched instruction with its PC in an output buffer. The buffer drives the decoder's 32-bit `inst` input through a valid/ready handshake. Control-flow redirects from execute (branch/JAL/JALR) flush the buffer and discard any in-flight stale response.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch byte address; always equals the current PC
- imem_gnt  in  1  memory accepts request this cycle when high with imem_req
- imem_rvalid  in  1  response data valid; earliest is 1 cycle after the grant
- imem_rdata  in  32  response instruction word
- redirect  in  1  control-flow change request from execute
- redirect_pc  in  32  redirect target
- inst_valid  out  1  output buffer holds an instruction
- inst_ready  in  1  decoder consumes the instruction when high with inst_valid
- inst  out  32  instruction word presented to the decoder
- inst_pc  out  32  PC of `inst`
- fetch_fault  out  1  misaligned redirect fault; exists only under the optional feature

Behaviour:
- Reset: pc=RESET_PC, state=REQ, inst_valid=0, inst=0, inst_pc=0, fetch_fault=0.
  - imem_req is 0 in the reset cycle.
  - A reset asserted mid-operation abandons any outstanding request; any later imem_rvalid is ignored until the next grant.
- At most one outstanding memory request.
- FSM states: REQ, WAIT, DRAIN.
- REQ:
  - imem_req = !inst_valid || inst_ready. This is a combinational dependency on inst_ready; it permits back-to-back issue while the buffer drains.
  - On imem_req && imem_gnt, go to WAIT.
- WAIT:
  - imem_req = 0.
  - On imem_rvalid: inst<=imem_rdata, inst_pc<=pc, inst_valid<=1, pc<=pc+PC_STEP, go to REQ.
- DRAIN:
  - imem_req = 0.
  - The next imem_rvalid is discarded; then go to REQ.
- Buffer: a consumed instruction (inst_valid && inst_ready) clears inst_valid unless it is refilled in the same cycle.
  - Refill and consume in the same cycle leaves inst_valid=1 with the new word.
- Sustained throughput with 1-cycle memory: one instruction per 2 cycles.
- Redirect has the highest priority, whatever the state. Every redirect sets pc<=redirect_pc and inst_valid<=0; it also drops a buffered instruction even if inst_ready=1 that cycle. The next state depends on the current state:
  - REQ, no grant this cycle: stay in REQ.
  - REQ with imem_req && imem_gnt this cycle: the issued request is stale; go to DRAIN.
  - WAIT without imem_rvalid: go to DRAIN.
  - WAIT with imem_rvalid the same cycle: discard the data, go to REQ.
  - DRAIN without imem_rvalid: stay in DRAIN (pc updated).
  - DRAIN with imem_rvalid the same cycle: discard, go to REQ.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no flag.
- Without the optional feature, redirect_pc[1:0] is forced to 2'b00 when loaded.

Optional Feature:
Macro INST_FETCH_MISALIGN_FAULT_EN.
- Defined:
  - A redirect with redirect_pc[1:0]!=0 loads pc unmasked, flushes the buffer and sets fetch_fault=1.
  - While fetch_fault=1, imem_req is held at 0 (after completing any required DRAIN).
  - The next aligned redirect clears fetch_fault and resumes fetching.
  - Reset clears fetch_fault.
- Not defined: the fetch_fault port is absent and low bits are masked as described above.

Test Plan:
- Reset, 1-cycle memory, inst_ready=1 → imem_addr 0x0,0x4,0x8 on successive grants; decoder sees inst_pc 0x0,0x4,0x8 each with the matching rdata; inst_valid high every other cycle.
- inst_ready=0 after the first instruction (0x00500093 at pc 0x0) → imem_req stays 0, inst/inst_pc held stable; raising inst_ready issues request 0x4 the same cycle.
- Redirect to 0x100 while in WAIT for 0x8 → the rvalid for 0x8 (data 0xDEADBEEF) is discarded and never reaches inst; the next request is 0x100 and inst_pc=0x100.
- Redirect and imem_rvalid in the same cycle → data dropped, inst_valid=0 the next cycle, request to the target issued the next cycle.
- Redirect to 0x200 while a buffered instruction is being consumed → inst_valid=0 the next cycle; the next inst_pc is 0x200.
- Under INST_FETCH_MISALIGN_FAULT_EN, redirect to 0x102 → fetch_fault=1 and no imem_req; then redirect to 0x104 → fault clears and the fetch at 0x104 proceeds.
